// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter in front of a simple dual-port RAM.
// After reset the whole RAM is swept to CLEAR_VALUE, then the read port and
// the write port are each arbitrated round-robin between requesters A and B.
module mem_port_arbiter #(
  parameter int                    DATA_WIDTH  = 14,
  parameter int                    ADDR_WIDTH  = 6,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic                    init_done_q;
  logic                    rd_pri_q;      // 0: A holds read priority, 1: B
  logic                    wr_pri_q;      // 0: A holds write priority, 1: B
  logic                    a_pend_q;      // read granted to A last cycle
  logic                    b_pend_q;
  logic                    fwd_valid_q;   // last cycle's read hit last cycle's write
  logic [DATA_WIDTH-1:0]   fwd_data_q;
  logic [DATA_WIDTH-1:0]   a_hold_q;
  logic [DATA_WIDTH-1:0]   b_hold_q;

  logic                    run_en;
  logic                    a_rd, b_rd, a_wr, b_wr;
  logic                    rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b;
  logic [ADDR_WIDTH-1:0]   rd_addr_sel;
  logic [ADDR_WIDTH-1:0]   wr_addr_sel;
  logic [DATA_WIDTH-1:0]   wr_data_sel;
  logic [DATA_WIDTH-1:0]   rd_resp;

  // Grants are only possible in RUN and never while reset is asserted.
  assign run_en = rst_n && (state_q == RUN);
  assign a_rd   = a_req & ~a_we;
  assign b_rd   = b_req & ~b_we;
  assign a_wr   = a_req & a_we;
  assign b_wr   = b_req & b_we;

  assign rd_gnt_a = run_en & a_rd & (~b_rd | ~rd_pri_q);
  assign rd_gnt_b = run_en & b_rd & ~rd_gnt_a;
  assign wr_gnt_a = run_en & a_wr & (~b_wr | ~wr_pri_q);
  assign wr_gnt_b = run_en & b_wr & ~wr_gnt_a;

  assign a_gnt = rd_gnt_a | wr_gnt_a;
  assign b_gnt = rd_gnt_b | wr_gnt_b;

  assign rd_addr_sel = rd_gnt_a ? a_addr  : b_addr;
  assign wr_addr_sel = wr_gnt_a ? a_addr  : b_addr;
  assign wr_data_sel = wr_gnt_a ? a_wdata : b_wdata;

  // RAM port drive: clear sweep in INIT, granted accesses in RUN.
  always_comb begin
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (rd_gnt_a || rd_gnt_b) begin
      mem_rd_addr = rd_addr_sel;
    end
    if (rst_n && state_q == INIT) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = clr_cnt_q;
      mem_wr_data = CLEAR_VALUE;
    end else if (wr_gnt_a || wr_gnt_b) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = wr_addr_sel;
      mem_wr_data = wr_data_sel;
    end
  end

  // Read responses come straight from the RAM (or the forwarding register)
  // in the cycle after the grant; otherwise the last delivered word is held.
  assign rd_resp   = fwd_valid_q ? fwd_data_q : mem_rd_data;
  assign a_rvalid  = a_pend_q & rst_n;
  assign b_rvalid  = b_pend_q & rst_n;
  assign a_rdata   = a_rvalid ? rd_resp : a_hold_q;
  assign b_rdata   = b_rvalid ? rd_resp : b_hold_q;
  assign init_done = init_done_q;

  // Sweep FSM, round-robin priority, read pipeline and forwarding state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      rd_pri_q    <= 1'b0;
      wr_pri_q    <= 1'b0;
      a_pend_q    <= 1'b0;
      b_pend_q    <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
    end else begin
      case (state_q)
        INIT: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          if (rd_gnt_a)      rd_pri_q <= 1'b1;
          else if (rd_gnt_b) rd_pri_q <= 1'b0;
          if (wr_gnt_a)      wr_pri_q <= 1'b1;
          else if (wr_gnt_b) wr_pri_q <= 1'b0;
        end
        default: state_q <= INIT;
      endcase
      a_pend_q    <= rd_gnt_a;
      b_pend_q    <= rd_gnt_b;
      // The RAM's read-during-write result is unknown, so a same-address
      // read/write pair is answered from here instead.
      fwd_valid_q <= (rd_gnt_a | rd_gnt_b) & (wr_gnt_a | wr_gnt_b)
                     & (rd_addr_sel == wr_addr_sel);
      fwd_data_q  <= wr_data_sel;
      if (a_pend_q) a_hold_q <= rd_resp;
      if (b_pend_q) b_hold_q <= rd_resp;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus against a cycle-level
// reference model (array memory, priority flags, expected responses).
module tb_mem_port_arbiter;

  localparam int DW = 14;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic          clk;
  logic          rst_n;
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, mem_wr_data;
  logic          mem_wr_en;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .init_done(init_done),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dual-port RAM with registered read, returning old data on a
  // same-address read/write.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_rd_addr];
  end

  // Reference model state.
  int            n_chk = 0;
  int            n_fail = 0;
  int            sweep_idx = 0;
  bit            rd_pri_b = 0;
  bit            wr_pri_b = 0;
  bit            exp_av = 0, exp_bv = 0;
  logic [DW-1:0] exp_ad = '0, exp_bd = '0;
  logic [DW-1:0] last_a = '0, last_b = '0;
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ar, input bit aw, input int aa, input int ad,
                       input bit br, input bit bw, input int ba, input int bd);
    a_req = ar; a_we = aw; a_addr = AW'(aa); a_wdata = DW'(ad);
    b_req = br; b_we = bw; b_addr = AW'(ba); b_wdata = DW'(bd);
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive_rand(input int amax);
    drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, amax), $urandom_range(0, 16383),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, amax), $urandom_range(0, 16383));
  endtask

  // One clock cycle: check outputs mid-cycle against the model, advance the
  // model by what should happen at the coming edge, then return after it.
  task automatic run_cycle();
    bit ga_r, gb_r, ga_w, gb_w;
    logic [AW-1:0] exp_rd_addr;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_a_gnt", 32'(a_gnt), 32'(0));
      chk("rst_b_gnt", 32'(b_gnt), 32'(0));
      chk("rst_wr_en", 32'(mem_wr_en), 32'(0));
      chk("rst_a_rvalid", 32'(a_rvalid), 32'(0));
      chk("rst_b_rvalid", 32'(b_rvalid), 32'(0));
      chk("rst_a_rdata", 32'(a_rdata), 32'(last_a));
      chk("rst_b_rdata", 32'(b_rdata), 32'(last_b));
      sweep_idx = 0; rd_pri_b = 0; wr_pri_b = 0;
      exp_av = 0; exp_bv = 0; last_a = '0; last_b = '0;
    end else begin
      chk("init_done", 32'(init_done), 32'(sweep_idx >= DEPTH));
      chk("a_rvalid", 32'(a_rvalid), 32'(exp_av));
      chk("b_rvalid", 32'(b_rvalid), 32'(exp_bv));
      chk("a_rdata", 32'(a_rdata), 32'(exp_av ? exp_ad : last_a));
      chk("b_rdata", 32'(b_rdata), 32'(exp_bv ? exp_bd : last_b));
      if (exp_av) last_a = exp_ad;
      if (exp_bv) last_b = exp_bd;
      exp_av = 0; exp_bv = 0;
      if (sweep_idx < DEPTH) begin
        chk("init_a_gnt", 32'(a_gnt), 32'(0));
        chk("init_b_gnt", 32'(b_gnt), 32'(0));
        chk("init_wr_en", 32'(mem_wr_en), 32'(1));
        chk("init_wr_addr", 32'(mem_wr_addr), 32'(sweep_idx));
        chk("init_wr_data", 32'(mem_wr_data), 32'(0));
        ref_mem[sweep_idx] = '0;
        sweep_idx++;
      end else begin
        ga_r = a_req && !a_we && !(b_req && !b_we && rd_pri_b);
        gb_r = b_req && !b_we && !ga_r;
        ga_w = a_req && a_we && !(b_req && b_we && wr_pri_b);
        gb_w = b_req && b_we && !ga_w;
        exp_rd_addr = ga_r ? a_addr : (gb_r ? b_addr : '0);
        chk("a_gnt", 32'(a_gnt), 32'(ga_r || ga_w));
        chk("b_gnt", 32'(b_gnt), 32'(gb_r || gb_w));
        chk("wr_en", 32'(mem_wr_en), 32'(ga_w || gb_w));
        chk("rd_addr", 32'(mem_rd_addr), 32'(exp_rd_addr));
        if (ga_w || gb_w) begin
          chk("wr_addr", 32'(mem_wr_addr), 32'(ga_w ? a_addr : b_addr));
          chk("wr_data", 32'(mem_wr_data), 32'(ga_w ? a_wdata : b_wdata));
          ref_mem[ga_w ? a_addr : b_addr] = ga_w ? a_wdata : b_wdata;
        end
        // A read sees this cycle's write, so look up after the update.
        if (ga_r) begin exp_av = 1; exp_ad = ref_mem[a_addr]; end
        if (gb_r) begin exp_bv = 1; exp_bd = ref_mem[b_addr]; end
        if (ga_r) rd_pri_b = 1; else if (gb_r) rd_pri_b = 0;
        if (ga_w) wr_pri_b = 1; else if (gb_w) wr_pri_b = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    // Reset cycle with requests present: no grant, no RAM write.
    drive(1, 1, 1, 1, 1, 0, 2, 0);
    run_cycle();
    rst_n = 1'b1;

    // Clear sweep with requests pending, then the first RUN cycle.
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1, $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 16383),
            1, $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 16383));
      run_cycle();
    end
    drive_idle(); run_cycle();

    // A writes 0x1234 to 5, then reads it back.
    drive(1, 1, 5, 'h1234, 0, 0, 0, 0); run_cycle();
    drive(1, 0, 5, 0, 0, 0, 0, 0);      run_cycle();
    drive_idle(); run_cycle();
    drive_idle(); run_cycle();

    // Continuous reads from both sides.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, $urandom_range(0, 63), 0, 1, 0, $urandom_range(0, 63), 0);
      run_cycle();
    end
    drive_idle(); run_cycle();

    // Same-address read (A) and write (B) in one cycle.
    drive(1, 0, 9, 0, 1, 1, 9, 'h0ABC); run_cycle();
    drive_idle(); run_cycle();

    // Contended writes for 4 cycles, then read two of the slots back.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 20 + i, $urandom_range(0, 16383), 1, 1, 30 + i, $urandom_range(0, 16383));
      run_cycle();
    end
    drive(1, 0, 20, 0, 1, 0, 31, 0); run_cycle();
    drive(1, 0, 22, 0, 1, 0, 33, 0); run_cycle();
    drive_idle(); run_cycle();
    drive_idle(); run_cycle();

    // Reset pulse right after a read grant, then the restarted sweep.
    drive(1, 0, 3, 0, 0, 0, 0, 0); run_cycle();
    drive_idle();
    rst_n = 1'b0; run_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_idle(); run_cycle();
    end

    // Random traffic over a small address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      drive_rand(7);
      run_cycle();
    end
    drive_idle(); run_cycle();
    drive_idle(); run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
